// File: rtl/note_tone_player.sv
// note_tone_player: note memory plus square-wave tone generator.
// Records note codes in load mode and plays them back by index.
module note_tone_player #(
  parameter int DIV_SHIFT  = 0,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_note,
  input  logic                  ld_play,
  input  logic [3:0]            note_in,
  input  logic [3:0]            note_counter,
  input  logic                  next_note_en,
  output logic                  audio_out,
  output logic [3:0]            current_note,
  output logic [DEPTH_LOG2:0]   notes_stored,
  output logic                  mem_full,
  output logic                  tone_active
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT =
    (DEPTH_LOG2+1)'(DEPTH);

  logic [3:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  ld_note_q;
  logic                  ld_play_q;
  logic [3:0]            cur_q, cur_d;
  logic [16:0]           tcnt_q, tcnt_d;
  logic                  aud_q, aud_d;

  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [3:0]            rd_code;
  logic                  play_ok;
  logic                  restart;
  logic                  ph_idle;
  logic                  ph_load;
  logic                  ph_wrap;
  logic                  ph_dec;

  // Raw half-period in clk cycles at 50 MHz, C4..C6.
  function automatic logic [16:0] hp_raw(
    input logic [3:0] c
  );
    logic [16:0] h;
    case (c)
      4'd1:    h = 17'd95556;
      4'd2:    h = 17'd85131;
      4'd3:    h = 17'd75843;
      4'd4:    h = 17'd71586;
      4'd5:    h = 17'd63776;
      4'd6:    h = 17'd56818;
      4'd7:    h = 17'd50619;
      4'd8:    h = 17'd47778;
      4'd9:    h = 17'd42565;
      4'd10:   h = 17'd37921;
      4'd11:   h = 17'd35793;
      4'd12:   h = 17'd31888;
      4'd13:   h = 17'd28409;
      4'd14:   h = 17'd25309;
      4'd15:   h = 17'd23889;
      default: h = 17'd0;
    endcase
    return h;
  endfunction

  // Counter reload value H-1; a zero half-period clamps to 0.
  function automatic logic [16:0] hp_reload(
    input logic [3:0] c
  );
    logic [16:0] h;
    h = hp_raw(c) >> DIV_SHIFT;
    return (h == 17'd0) ? 17'd0 : h - 17'd1;
  endfunction

  assign wr_ptr  = cnt_q[DEPTH_LOG2-1:0];
  assign rd_ptr  = note_counter[DEPTH_LOG2-1:0];
  assign rd_code = mem_q[rd_ptr];

  assign mem_full = (cnt_q == FULL_CNT);
  assign wr_en    = ld_note & ~ld_note_q & ~mem_full;

  // Loading while playing is illegal; the write wins.
  assign play_ok = ld_play & ~ld_note;

  assign restart = play_ok &
    (~ld_play_q | next_note_en | (rd_code != cur_q));

  assign ph_load = restart;
  assign ph_idle = ~play_ok |
    (~restart & (cur_q == 4'd0));
  assign ph_wrap = play_ok & ~restart &
    (cur_q != 4'd0) & (tcnt_q == 17'd0);
  assign ph_dec  = play_ok & ~restart &
    (cur_q != 4'd0) & (tcnt_q != 17'd0);

  // Write count saturates at full depth.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_en) cnt_d = cnt_q + 1'b1;
  end

  // Sound the indexed note only in clean playback.
  always_comb begin
    cur_d = 4'd0;
    if (play_ok) cur_d = rd_code;
  end

  // Phase counter and square-wave output.
  always_comb begin
    tcnt_d = tcnt_q;
    aud_d  = aud_q;
    unique case (1'b1)
      ph_idle: begin
        tcnt_d = 17'd0;
        aud_d  = 1'b0;
      end
      ph_load: begin
        tcnt_d = hp_reload(rd_code);
        aud_d  = 1'b0;
      end
      ph_wrap: begin
        tcnt_d = hp_reload(cur_q);
        aud_d  = ~aud_q;
      end
      ph_dec: begin
        tcnt_d = tcnt_q - 17'd1;
      end
      default: begin
        tcnt_d = 17'd0;
        aud_d  = 1'b0;
      end
    endcase
  end

  // Note memory; cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= 4'd0;
    end else if (wr_en) begin
      mem_q[wr_ptr] <= note_in;
    end
  end

  // Control, note and tone state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      ld_note_q <= 1'b0;
      ld_play_q <= 1'b0;
      cur_q     <= 4'd0;
      tcnt_q    <= 17'd0;
      aud_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ld_note_q <= ld_note;
      ld_play_q <= ld_play;
      cur_q     <= cur_d;
      tcnt_q    <= tcnt_d;
      aud_q     <= aud_d;
    end
  end

  assign audio_out    = aud_q;
  assign current_note = cur_q;
  assign notes_stored = cnt_q;
  assign tone_active  = ld_play & (cur_q != 4'd0);

endmodule

// File: tb/tb_note_tone_player.sv
// tb_note_tone_player: directed checks of
// note storage, playback and tone periods.
module tb_note_tone_player;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld_note;
  logic       ld_play;
  logic [3:0] note_in;
  logic [3:0] note_counter;
  logic       next_note_en;
  logic       audio_out;
  logic [3:0] current_note;
  logic [4:0] notes_stored;
  logic       mem_full;
  logic       tone_active;

  int n_tests = 0;
  int n_fail  = 0;
  int per;
  logic seen_hi;

  note_tone_player #(
    .DIV_SHIFT (10),
    .DEPTH_LOG2(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ld_note     (ld_note),
    .ld_play     (ld_play),
    .note_in     (note_in),
    .note_counter(note_counter),
    .next_note_en(next_note_en),
    .audio_out   (audio_out),
    .current_note(current_note),
    .notes_stored(notes_stored),
    .mem_full    (mem_full),
    .tone_active (tone_active)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] code);
    note_in = code;
    ld_note = 1'b1;
    tick();
    ld_note = 1'b0;
    tick();
  endtask

  task automatic wait_toggle(output int n);
    logic p;
    p = audio_out;
    n = 0;
    while (n < 400) begin
      tick();
      n++;
      if (audio_out !== p) break;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    ld_note      = 1'b0;
    ld_play      = 1'b0;
    note_in      = 4'd0;
    note_counter = 4'd0;
    next_note_en = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_stored", notes_stored, 0);
    chk("rst_audio", audio_out, 0);
    chk("rst_note", current_note, 0);
    chk("rst_full", mem_full, 0);
    chk("rst_active", tone_active, 0);
    reset = 1'b0;
    tick();

    // Held ld_note writes once
    note_in = 4'd6;
    ld_note = 1'b1;
    repeat (20) tick();
    ld_note = 1'b0;
    tick();
    chk("single_stored", notes_stored, 1);

    // Play code 6: H = 55
    note_counter = 4'd0;
    ld_play = 1'b1;
    tick();
    chk("play6_note", current_note, 6);
    chk("play6_audio0", audio_out, 0);
    chk("play6_active", tone_active, 1);
    wait_toggle(per);
    chk("play6_rise", per, 55);
    chk("play6_hi", audio_out, 1);
    wait_toggle(per);
    chk("play6_fall", per, 55);

    // Reset in the middle of playback
    ld_play = 1'b0;
    tick();
    wr(4'd7);
    wr(4'd9);
    chk("three_stored", notes_stored, 3);
    ld_play = 1'b1;
    repeat (60) tick();
    chk("pre_rst_audio", audio_out, 1);
    do_reset();
    chk("midrst_stored", notes_stored, 0);
    chk("midrst_audio", audio_out, 0);
    chk("midrst_note", current_note, 0);
    tick();
    chk("midrst_mem0", current_note, 0);
    chk("midrst_active", tone_active, 0);

    // Saturation: 17 writes
    ld_play = 1'b0;
    tick();
    for (int i = 1; i <= 15; i++)
      wr(4'(i));
    wr(4'd1);
    chk("sat16_stored", notes_stored, 16);
    chk("sat16_full", mem_full, 1);
    wr(4'd2);
    chk("sat17_stored", notes_stored, 16);
    chk("sat17_full", mem_full, 1);
    note_counter = 4'd15;
    ld_play = 1'b1;
    tick();
    chk("sat_mem15", current_note, 1);
    wait_toggle(per);
    chk("sat_h93", per, 93);
    note_counter = 4'd13;
    tick();
    chk("sat_mem13", current_note, 14);

    // Note change with phase restart
    ld_play = 1'b0;
    do_reset();
    wr(4'd1);
    wr(4'd8);
    note_counter = 4'd0;
    ld_play = 1'b1;
    tick();
    chk("chg_note1", current_note, 1);
    wait_toggle(per);
    chk("chg_h93", per, 93);
    chk("chg_hi", audio_out, 1);
    note_counter = 4'd1;
    next_note_en = 1'b1;
    tick();
    next_note_en = 1'b0;
    chk("chg_note8", current_note, 8);
    chk("chg_restart0", audio_out, 0);
    wait_toggle(per);
    chk("chg_h46a", per, 46);
    wait_toggle(per);
    chk("chg_h46b", per, 46);

    // Rest then pitched note
    ld_play = 1'b0;
    do_reset();
    wr(4'd0);
    wr(4'd13);
    note_counter = 4'd0;
    ld_play = 1'b1;
    tick();
    chk("rest_note", current_note, 0);
    chk("rest_active", tone_active, 0);
    seen_hi = 1'b0;
    repeat (60) begin
      tick();
      seen_hi = seen_hi | audio_out;
    end
    chk("rest_silent", seen_hi, 0);
    note_counter = 4'd1;
    tick();
    chk("n13_note", current_note, 13);
    chk("n13_active", tone_active, 1);
    wait_toggle(per);
    chk("n13_h27", per, 27);

    // ld_note rising while playing
    note_in = 4'd5;
    ld_note = 1'b1;
    tick();
    chk("ovl_stored", notes_stored, 3);
    chk("ovl_note", current_note, 0);
    chk("ovl_audio", audio_out, 0);
    chk("ovl_active", tone_active, 0);
    ld_note = 1'b0;
    tick();
    chk("ovl_resume", current_note, 13);
    note_counter = 4'd2;
    tick();
    chk("ovl_mem2", current_note, 5);

    // next_note_en while idle
    ld_play = 1'b0;
    next_note_en = 1'b1;
    tick();
    next_note_en = 1'b0;
    tick();
    chk("idle_note", current_note, 0);
    chk("idle_audio", audio_out, 0);
    chk("idle_active", tone_active, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
